// File: rtl/phone_capture_pkg.sv
// Shared types and widths for the phone input-capture stage.
//   state_t  : debounce FSM states
//   PHONE_W  : width of the raw phone pin bus
//   BUS_W    : width of the writeback-mux data path
//   bit_rev  : maps pin order (bit i = in_i) to mux order (bit 7-i = in_i)
package phone_capture_pkg;

  localparam int unsigned PHONE_W = 8;
  localparam int unsigned BUS_W   = 16;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  function automatic logic [PHONE_W-1:0] bit_rev(input logic [PHONE_W-1:0] v);
    logic [PHONE_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(PHONE_W); i++) begin
      r[int'(PHONE_W) - 1 - i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/phone_capture_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears both stages
//   i_d : asynchronous input bus
//   o_q : synchronized bus, two edges behind i_d
module phone_capture_sync2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/phone_capture.sv
// Phone pin capture: synchronize, debounce and hold each settled pin value
// for the control FSM behind a valid/ack handshake.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   in_pins  : raw phone pins (bit i = in_i), asynchronous to clk
//   ack      : one-cycle pulse, data_out consumed
//   data_out : {8'h00, bit-reversed settled value}
//   valid    : unread value held in data_out
//   overrun  : sticky, an unread value was overwritten
//   busy     : a pin change is currently settling
module phone_capture
  import phone_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHONE_W-1:0] in_pins,
  input  logic               ack,
  output logic [BUS_W-1:0]   data_out,
  output logic               valid,
  output logic               overrun,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [PHONE_W-1:0] w_s2;
  logic               w_commit;

  state_t             r_state;
  logic [PHONE_W-1:0] r_cand;
  logic [PHONE_W-1:0] r_stable;
  logic [CNT_W-1:0]   r_cnt;
  logic [BUS_W-1:0]   r_data;
  logic               r_valid;
  logic               r_overrun;
  logic               r_busy;

  phone_capture_sync2 #(
    .W (PHONE_W)
  ) u_sync2 (
    .clk (clk),
    .rst (rst),
    .i_d (in_pins),
    .o_q (w_s2)
  );

  // Settle window completes with the candidate held; a bounce back to the
  // old value completes the window too but is not a new value.
  assign w_commit = (r_state == ST_SETTLING) && (w_s2 == r_cand) &&
                    (r_cnt == CNT_LAST) && (r_cand != r_stable);

  // Debounce FSM, settle counter and capture/handshake register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_STABLE;
      r_cand    <= '0;
      r_stable  <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_STABLE: begin
          if (w_s2 != r_stable) begin
            r_cand  <= w_s2;
            r_cnt   <= '0;
            r_state <= ST_SETTLING;
            r_busy  <= 1'b1;
          end
        end
        ST_SETTLING: begin
          if (w_s2 != r_cand) begin
            // Bus moved again: restart the settle window on the new value.
            r_cand <= w_s2;
            r_cnt  <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_cand;
            r_state  <= ST_STABLE;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_commit) begin
        r_data  <= {{(BUS_W - PHONE_W){1'b0}}, bit_rev(r_cand)};
        r_valid <= 1'b1;
        // An ack on the commit edge consumed the old value, so no overrun.
        r_overrun <= r_overrun ? !ack : (r_valid && !ack);
      end else if (ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign data_out = r_data;
  assign valid    = r_valid;
  assign overrun  = r_overrun;
  assign busy     = r_busy;

endmodule
